countdown_timer: RTL and testbench



---
 rtl/countdown_timer_pkg.sv | 12 +
 rtl/countdown_timer.sv | 98 +++++++++
 tb/tb_countdown_timer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the FSM lab blocks: state encoding and default counter width.
package countdown_timer_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause, restart and auto-reload; pulses done at terminal count.
import countdown_timer_pkg::*;

module countdown_timer #(
  parameter int N = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] load_val,
  input  logic         start,
  input  logic         pause,
  input  logic         auto_reload,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done
);

  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ZERO = '0;

  state_t       state, state_nxt;
  logic [N-1:0] reload, reload_nxt;
  logic [N-1:0] q_nxt;
  logic         done_nxt;
  logic         busy_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      q      <= ZERO;
      reload <= ZERO;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      reload <= reload_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  // Priority: start > terminal count > pause.
  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    reload_nxt = reload;
    done_nxt   = 1'b0;

    if (start) begin
      q_nxt      = load_val;
      reload_nxt = load_val;
      if (load_val != ZERO) begin
        state_nxt = ST_RUN;
      end else begin
        // Zero-length timer: finishes immediately without ever being busy.
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_nxt = ST_IDLE;
        end
        ST_RUN: begin
          if (q == ONE) begin
            done_nxt = 1'b1;
            if (auto_reload) begin
              q_nxt = reload;
            end else begin
              q_nxt     = ZERO;
              state_nxt = ST_IDLE;
            end
          end else if (q == ZERO) begin
            // Unreachable in normal operation; fall back to a clean idle.
            state_nxt = ST_IDLE;
          end else if (pause) begin
            state_nxt = ST_PAUSED;
          end else begin
            q_nxt = q - ONE;
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_nxt = ST_RUN;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          q_nxt     = ZERO;
        end
      endcase
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: vector table plus hand-written reset and long-count sequences.
module tb_countdown_timer;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic [N-1:0] load_val;
  logic         start;
  logic         pause;
  logic         auto_reload;
  logic [N-1:0] q;
  logic         busy;
  logic         done;

  int checks;
  int failures;

  typedef struct {
    logic         start;
    logic [N-1:0] load_val;
    logic         pause;
    logic         auto_reload;
    logic [N-1:0] exp_q;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  vec_t vecs[$];

  countdown_timer #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_val    (load_val),
    .start       (start),
    .pause       (pause),
    .auto_reload (auto_reload),
    .q           (q),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic add(input logic s, input logic [N-1:0] lv, input logic p, input logic ar,
                     input logic [N-1:0] eq, input logic eb, input logic ed);
    vec_t v;
    v.start = s; v.load_val = lv; v.pause = p; v.auto_reload = ar;
    v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    start = 1'b0; load_val = '0; pause = 1'b0; auto_reload = 1'b0;
  endtask

  initial begin
    int cyc;
    int done_cnt;
    checks = 0;
    failures = 0;

    // One-shot, L=5
    add(1, 5, 0, 0, 5, 1, 0);
    add(0, 0, 0, 0, 4, 1, 0);
    add(0, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 0, 2, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    // Pause in IDLE has no effect
    add(0, 0, 1, 0, 0, 0, 0);
    // Pause: load 10, frozen at 7, finishes four edges late
    add(1, 10, 0, 0, 10, 1, 0);
    add(0, 0, 0, 0, 9, 1, 0);
    add(0, 0, 0, 0, 8, 1, 0);
    add(0, 0, 0, 0, 7, 1, 0);
    add(0, 0, 1, 0, 7, 1, 0);
    add(0, 0, 1, 0, 7, 1, 0);
    add(0, 0, 1, 0, 7, 1, 0);
    add(0, 0, 0, 0, 7, 1, 0);
    add(0, 0, 0, 0, 6, 1, 0);
    add(0, 0, 0, 0, 5, 1, 0);
    add(0, 0, 0, 0, 4, 1, 0);
    add(0, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 0, 2, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    // Pause on the terminal edge is ignored
    add(1, 2, 0, 0, 2, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    // Auto-reload L=3, then cleared mid-count
    add(1, 3, 0, 1, 3, 1, 0);
    add(0, 0, 0, 1, 2, 1, 0);
    add(0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 3, 1, 1);
    add(0, 0, 0, 1, 2, 1, 0);
    add(0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 3, 1, 1);
    add(0, 0, 0, 0, 2, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    // Restart while running: no done
    add(1, 6, 0, 0, 6, 1, 0);
    add(0, 0, 0, 0, 5, 1, 0);
    add(0, 0, 0, 0, 4, 1, 0);
    add(1, 9, 0, 0, 9, 1, 0);
    add(0, 0, 0, 0, 8, 1, 0);
    // Start with zero while running: immediate done, idle
    add(1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    // Zero-length timer from IDLE
    add(1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    // Auto-reload L=1: done every cycle
    add(1, 1, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 1, 1, 1);
    add(0, 0, 0, 1, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    // Start and pause together in IDLE, then start from PAUSED
    add(1, 4, 1, 0, 4, 1, 0);
    add(0, 0, 1, 0, 4, 1, 0);
    add(0, 0, 1, 0, 4, 1, 0);
    add(0, 0, 0, 0, 4, 1, 0);
    add(0, 0, 0, 0, 3, 1, 0);
    add(0, 0, 1, 0, 3, 1, 0);
    add(1, 7, 0, 0, 7, 1, 0);
    add(0, 0, 0, 0, 6, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0);

    idle_inputs();
    reset = 1'b1;
    #12;
    reset = 1'b0;
    #1;
    check("reset_q", int'(q), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);

    foreach (vecs[i]) begin
      start       = vecs[i].start;
      load_val    = vecs[i].load_val;
      pause       = vecs[i].pause;
      auto_reload = vecs[i].auto_reload;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].exp_q));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].exp_done));
    end

    // Reset mid-count: load 20, five decrements, asynchronous reset between edges
    start = 1'b1; load_val = 8'd20;
    @(posedge clk); #1;
    idle_inputs();
    repeat (5) @(posedge clk);
    #1;
    check("midreset_pre_q", int'(q), 15);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_q", int'(q), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    #2;
    reset = 1'b0;
    done_cnt = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("midreset_no_done", done_cnt, 0);
    check("midreset_hold_q", int'(q), 0);

    // Full-scale load: done exactly 255 edges after start
    start = 1'b1; load_val = 8'd255;
    @(posedge clk); #1;
    idle_inputs();
    check("max_load_q", int'(q), 255);
    cyc = 0;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("max_load_latency", cyc, 255);
    check("max_load_end_q", int'(q), 0);
    check("max_load_end_busy", int'(busy), 0);
    @(posedge clk); #1;
    check("max_load_done_width", int'(done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
